seg_mux_scheduler: RTL



---
 rtl/seg_mux_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg_mux_scheduler.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS double-buffered hex digits onto
// one shared segment bus with a blanking gap between digits and optional leading-zero blanking.
module seg_mux_scheduler #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 25000,
    parameter int unsigned BLANK_CYCLES = 250,
    parameter bit          ACTIVE_LOW   = 1'b1,
    localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    lzb_en_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    frame_o,
    output logic [IDX_W-1:0]        idx_o
);

    localparam int unsigned MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [6:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      en_q, en_d;
    logic                       frame_q, frame_d;
    logic                       frame_start;
    logic [NUM_DIGITS-1:0][3:0] shadow_q;
    logic [NUM_DIGITS-1:0][3:0] display_q;
    logic [NUM_DIGITS-1:0]      lzb_mask;
    logic                       zero_run;

    // Logical segment pattern (1 = lit), A in bit 6 down to G in bit 0.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // A digit is a leading zero if it and every more-significant digit is zero; digit 0 never is.
    always_comb begin
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_run    = zero_run & (display_q[k] == 4'd0);
            lzb_mask[k] = zero_run;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            en_q    <= EN_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    // Pin values are only recomputed on state transitions so they hold steady within a state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        seg_d       = seg_q;
        en_d        = en_q;
        frame_start = 1'b0;

        if (!enable_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
            seg_d   = SEG_OFF;
            en_d    = EN_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d     = ST_BLANK;
                    cnt_d       = BLANK_LOAD;
                    idx_d       = '0;
                    seg_d       = SEG_OFF;
                    en_d        = EN_OFF;
                    frame_start = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = DWELL_LOAD;
                        en_d    = (NUM_DIGITS'(1) << idx_q) ^ EN_OFF;
                        seg_d   = (lzb_en_i && lzb_mask[idx_q]) ? SEG_OFF
                                : (seg_decode(display_q[idx_q]) ^ SEG_OFF);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d     = ST_BLANK;
                        cnt_d       = BLANK_LOAD;
                        idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        seg_d       = SEG_OFF;
                        en_d        = EN_OFF;
                        frame_start = (idx_q == LAST_IDX);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                    seg_d   = SEG_OFF;
                    en_d    = EN_OFF;
                end
            endcase
        end
        frame_d = frame_start;
    end

    // Shadow always loads; display updates only at frame start, with a same-cycle load taking priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q  <= '0;
            display_q <= '0;
        end else begin
            if (load_i) begin
                shadow_q <= digits_i;
            end
            if (frame_start) begin
                display_q <= load_i ? digits_i : shadow_q;
            end
        end
    end

    assign seg_o    = seg_q;
    assign dig_en_o = en_q;
    assign frame_o  = frame_q;
    assign idx_o    = idx_q;

endmodule
